// File: rtl/oled_ctrl_fsm_if.sv
// Handshake bundle between the vending FSM / OLED driver and the oled_ctrl_fsm sequencer.
// The slave modport is the sequencer side; the master modport is the event/ack source side.
interface oled_ctrl_fsm_if;
    logic       price_evt;
    logic       coin_evt;
    logic       disp_evt;
    logic       oled_ack;
    logic       clr_reg;
    logic       ld_price;
    logic       ld_cents;
    logic       ld_coins;
    logic       ld_disp;
    logic       line_req;
    logic [1:0] line_sel;
    logic       busy;
    logic       ack_err;

    modport master (
        output price_evt, coin_evt, disp_evt, oled_ack,
        input  clr_reg, ld_price, ld_cents, ld_coins, ld_disp,
        input  line_req, line_sel, busy, ack_err
    );

    modport slave (
        input  price_evt, coin_evt, disp_evt, oled_ack,
        output clr_reg, ld_price, ld_cents, ld_coins, ld_disp,
        output line_req, line_sel, busy, ack_err
    );
endinterface

// File: rtl/oled_ctrl_fsm.sv
// Sequencer for oled_datapath: latches vending events, drives register loads/clears and
// handshakes OLED line redraws with an ack timeout and a timed dispense hold.
module oled_ctrl_fsm #(
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned ACK_TIMEOUT = 1024
) (
    input  logic           clk,
    input  logic           rst_n,
    oled_ctrl_fsm_if.slave bus
);

    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

    typedef enum logic [3:0] {
        S_INIT, S_IDLE, S_LOAD_P, S_LOAD_C, S_LOAD_D,
        S_REQ, S_GAP, S_HOLD, S_CLEAR
    } state_t;

    state_t        state_q, state_d;
    logic          pend_p_q, pend_p_d;
    logic          pend_c_q, pend_c_d;
    logic          pend_d_q, pend_d_d;
    logic [3:0]    lines_q, lines_d;
    logic          hold_after_q, hold_after_d;
    logic          ack_err_q, ack_err_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic [AW-1:0] tmo_cnt_q, tmo_cnt_d;

    logic       clr_c, ld_p_c, ld_c_c, ld_d_c, req_c, busy_c;
    logic [1:0] cur_sel;
    logic [3:0] lines_rem;

    // Queued lines are always serviced lowest index first, which matches every queue order.
    always_comb begin
        cur_sel = 2'd0;
        if (lines_q[0])      cur_sel = 2'd0;
        else if (lines_q[1]) cur_sel = 2'd1;
        else if (lines_q[2]) cur_sel = 2'd2;
        else if (lines_q[3]) cur_sel = 2'd3;
        lines_rem = lines_q & ~(4'b0001 << cur_sel);
    end

    always_comb begin
        state_d      = state_q;
        lines_d      = lines_q;
        hold_after_d = hold_after_q;
        ack_err_d    = ack_err_q;
        hold_cnt_d   = hold_cnt_q;
        tmo_cnt_d    = tmo_cnt_q;
        clr_c        = 1'b0;
        ld_p_c       = 1'b0;
        ld_c_c       = 1'b0;
        ld_d_c       = 1'b0;
        req_c        = 1'b0;
        busy_c       = 1'b1;

        case (state_q)
            S_INIT: begin
                clr_c   = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                busy_c = 1'b0;
                if (pend_d_q)      state_d = S_LOAD_D;
                else if (pend_c_q) state_d = S_LOAD_C;
                else if (pend_p_q) state_d = S_LOAD_P;
            end
            S_LOAD_P: begin
                ld_p_c    = 1'b1;
                lines_d   = 4'b0001;
                tmo_cnt_d = '0;
                state_d   = S_REQ;
            end
            S_LOAD_C: begin
                ld_c_c    = 1'b1;
                lines_d   = 4'b0110;
                tmo_cnt_d = '0;
                state_d   = S_REQ;
            end
            S_LOAD_D: begin
                ld_d_c       = 1'b1;
                lines_d      = 4'b1000;
                hold_after_d = 1'b1;
                tmo_cnt_d    = '0;
                state_d      = S_REQ;
            end
            S_REQ: begin
                req_c = 1'b1;
                // An ack on the expiry cycle still wins over the timeout.
                if (bus.oled_ack) begin
                    lines_d   = lines_rem;
                    tmo_cnt_d = '0;
                    if (lines_rem != 4'b0000) begin
                        state_d = S_GAP;
                    end else if (hold_after_q) begin
                        hold_cnt_d = '0;
                        state_d    = S_HOLD;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else if (tmo_cnt_q == ACK_LAST) begin
                    ack_err_d    = 1'b1;
                    lines_d      = 4'b0000;
                    hold_after_d = 1'b0;
                    tmo_cnt_d    = '0;
                    state_d      = S_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + AW'(1);
                end
            end
            S_GAP: begin
                state_d = S_REQ;
            end
            S_HOLD: begin
                if (hold_cnt_q == HOLD_LAST) begin
                    hold_cnt_d = '0;
                    state_d    = S_CLEAR;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_CLEAR: begin
                clr_c        = 1'b1;
                lines_d      = 4'b1111;
                hold_after_d = 1'b0;
                tmo_cnt_d    = '0;
                state_d      = S_REQ;
            end
            default: begin
                state_d = S_INIT;
            end
        endcase

        // A new event on the clearing edge keeps its flag set.
        pend_p_d = bus.price_evt | (pend_p_q & ~(state_q == S_IDLE && state_d == S_LOAD_P));
        pend_c_d = bus.coin_evt  | (pend_c_q & ~(state_q == S_IDLE && state_d == S_LOAD_C));
        pend_d_d = bus.disp_evt  | (pend_d_q & ~(state_q == S_IDLE && state_d == S_LOAD_D));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            pend_p_q     <= 1'b0;
            pend_c_q     <= 1'b0;
            pend_d_q     <= 1'b0;
            lines_q      <= 4'b0000;
            hold_after_q <= 1'b0;
            ack_err_q    <= 1'b0;
            hold_cnt_q   <= '0;
            tmo_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            pend_p_q     <= pend_p_d;
            pend_c_q     <= pend_c_d;
            pend_d_q     <= pend_d_d;
            lines_q      <= lines_d;
            hold_after_q <= hold_after_d;
            ack_err_q    <= ack_err_d;
            hold_cnt_q   <= hold_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
        end
    end

    // INIT is the reset state, but its clear pulse must only appear once reset is released.
    assign bus.clr_reg  = clr_c & rst_n;
    assign bus.ld_price = ld_p_c;
    assign bus.ld_cents = ld_c_c;
    assign bus.ld_coins = ld_c_c;
    assign bus.ld_disp  = ld_d_c;
    assign bus.line_req = req_c;
    assign bus.line_sel = cur_sel;
    assign bus.busy     = busy_c;
    assign bus.ack_err  = ack_err_q;

endmodule

// File: tb/tb_oled_ctrl_fsm.sv
// Randomized bench for oled_ctrl_fsm: a script-based reference model expands each serviced
// event into the expected per-cycle output sequence and chooses the OLED ack timing itself.
module tb_oled_ctrl_fsm;

    localparam int HOLD = 8;
    localparam int TMO  = 4;

    logic clk;
    logic rst_n;

    oled_ctrl_fsm_if bus ();

    oled_ctrl_fsm #(
        .HOLD_CYCLES (HOLD),
        .ACK_TIMEOUT (TMO)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        bit       clr;
        bit       ldp;
        bit       ldc;
        bit       ldd;
        bit       req;
        bit [1:0] sel;
        bit       busy;
        bit       ack;
        bit       err_set;
        bit       hold;
    } exp_t;

    exp_t   q_exp[$];
    bit     pend[3];
    bit     err_m;
    int     n_checks;
    int     n_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t busy_entry();
        exp_t e;
        e = '0;
        e.busy = 1'b1;
        return e;
    endfunction

    // Expected requests for the lines in mask (lowest first), with a one-cycle gap between them.
    task automatic emit_lines(input logic [3:0] mask, output bit ok);
        bit   first;
        exp_t e;
        int   d;
        ok    = 1'b1;
        first = 1'b1;
        for (int l = 0; l < 4; l++) begin
            if (mask[l]) begin
                if (!first) q_exp.push_back(busy_entry());
                first = 1'b0;
                if ($urandom_range(0, 7) == 0) begin
                    for (int i = 0; i < TMO; i++) begin
                        e = busy_entry();
                        e.req = 1'b1;
                        e.sel = 2'(l);
                        e.err_set = (i == TMO - 1);
                        q_exp.push_back(e);
                    end
                    ok = 1'b0;
                    return;
                end
                d = $urandom_range(0, TMO - 1);
                for (int i = 0; i <= d; i++) begin
                    e = busy_entry();
                    e.req = 1'b1;
                    e.sel = 2'(l);
                    e.ack = (i == d);
                    q_exp.push_back(e);
                end
            end
        end
    endtask

    // k: 0 = price, 1 = coin, 2 = dispense
    task automatic build(input int k);
        exp_t       e;
        bit         ok;
        logic [3:0] m;
        e = busy_entry();
        if (k == 0) begin e.ldp = 1'b1; m = 4'b0001; end
        else if (k == 1) begin e.ldc = 1'b1; m = 4'b0110; end
        else begin e.ldd = 1'b1; m = 4'b1000; end
        q_exp.push_back(e);
        emit_lines(m, ok);
        if (k == 2 && ok) begin
            for (int i = 0; i < HOLD; i++) begin
                e = busy_entry();
                e.hold = 1'b1;
                q_exp.push_back(e);
            end
            e = busy_entry();
            e.clr = 1'b1;
            q_exp.push_back(e);
            emit_lines(4'b1111, ok);
        end
    endtask

    task automatic model_reset();
        exp_t e;
        q_exp.delete();
        for (int i = 0; i < 3; i++) pend[i] = 1'b0;
        err_m = 1'b0;
        e = busy_entry();
        e.clr = 1'b1;
        q_exp.push_back(e);
    endtask

    // Entered and left at 1 time unit after a rising edge.
    task automatic run_cycle(input int cyc);
        exp_t        cur;
        bit          from_q;
        bit          ev[3];
        logic [10:0] got, exp;
        int          k;
        from_q = (q_exp.size() != 0);
        cur    = from_q ? q_exp[0] : exp_t'('0);
        ev[0]  = ($urandom_range(0, 19) == 0);
        ev[1]  = ($urandom_range(0, 24) == 0);
        ev[2]  = ($urandom_range(0, 39) == 0);
        if (cyc == 3) begin
            ev[0] = 1'b1;
            ev[1] = 1'b1;
        end
        bus.price_evt = ev[0];
        bus.coin_evt  = ev[1];
        bus.disp_evt  = ev[2];
        bus.oled_ack  = cur.req ? cur.ack : ($urandom_range(0, 3) == 0);
        @(negedge clk);
        got = {bus.clr_reg, bus.ld_price, bus.ld_cents, bus.ld_coins, bus.ld_disp,
               bus.line_req, (cur.req ? bus.line_sel : 2'b00), bus.busy, bus.ack_err};
        exp = {cur.clr, cur.ldp, cur.ldc, cur.ldc, cur.ldd,
               cur.req, cur.sel, cur.busy, err_m};
        chk("cycle", 32'(got), 32'(exp));
        if (from_q) begin
            if (cur.err_set) err_m = 1'b1;
            void'(q_exp.pop_front());
        end else if (pend[0] || pend[1] || pend[2]) begin
            k = pend[2] ? 2 : (pend[1] ? 1 : 0);
            pend[k] = 1'b0;
            build(k);
            $display("txn t=%0t load=%s queued_cycles=%0d", $time,
                     (k == 2) ? "disp" : ((k == 1) ? "coin" : "price"), q_exp.size());
        end
        for (int i = 0; i < 3; i++) pend[i] = pend[i] | ev[i];
        @(posedge clk);
        #1;
    endtask

    task automatic check_in_reset(input string tag);
        chk({tag, "_line_req"}, 32'(bus.line_req), 32'd0);
        chk({tag, "_busy"},     32'(bus.busy),     32'd1);
        chk({tag, "_clr_reg"},  32'(bus.clr_reg),  32'd0);
        chk({tag, "_ack_err"},  32'(bus.ack_err),  32'd0);
    endtask

    initial begin
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        bus.price_evt = 1'b0;
        bus.coin_evt  = 1'b0;
        bus.disp_evt  = 1'b0;
        bus.oled_ack  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_in_reset("rst0");
        rst_n = 1'b1;
        model_reset();

        for (int seg = 0; seg < 3; seg++) begin
            for (int c = 0; c < 1500; c++) run_cycle(c);
            // Try to land the reset inside a dispense hold window.
            for (int w = 0; w < 400; w++) begin
                if (q_exp.size() != 0 && q_exp[0].hold) break;
                run_cycle(w + 10);
            end
            bus.price_evt = 1'b0;
            bus.coin_evt  = 1'b0;
            bus.disp_evt  = 1'b0;
            bus.oled_ack  = 1'b0;
            #1;
            rst_n = 1'b0;
            #1;
            check_in_reset("rst_mid");
            @(posedge clk);
            #1;
            check_in_reset("rst_hold");
            rst_n = 1'b1;
            model_reset();
        end
        for (int c = 0; c < 300; c++) run_cycle(c);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
